// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Contents: FSM state enum, vector/error/counter widths, the standard 2-input
// truth tables (bit index = {a,b}), and a truth-table lookup helper.
package gate_tt_pkg;

    localparam int unsigned VEC_COUNT = 4;
    localparam int unsigned VEC_W     = 2;
    localparam int unsigned ERR_W     = 3;
    localparam int unsigned CNT_W     = 4;

    localparam logic [VEC_COUNT-1:0] TT_AND  = 4'b1000;
    localparam logic [VEC_COUNT-1:0] TT_NAND = 4'b0111;
    localparam logic [VEC_COUNT-1:0] TT_OR   = 4'b1110;
    localparam logic [VEC_COUNT-1:0] TT_NOR  = 4'b0001;
    localparam logic [VEC_COUNT-1:0] TT_XOR  = 4'b0110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Expected gate output for input vector {a,b}.
    function automatic logic tt_expect(input logic [VEC_COUNT-1:0] tt,
                                       input logic [VEC_W-1:0]     vec);
        return tt[vec];
    endfunction

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Loadable down-counter that times how long each vector is held.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load_i      load value_i into the counter (wins over dec_i)
//   dec_i       decrement by one; holds at zero
//   value_i     load value
//   zero_c_o    counter is zero (combinational from the count register)
module gate_tt_settle_timer
    import gate_tt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Stimulus/response checker for 2-input gate cells: walks {a,b} through
// 00,01,10,11, holds each vector SETTLE_CYCLES cycles, samples the gate output
// and compares it with EXPECT_TT, reporting pass/fail and a mismatch count.
// Optional macro GATE_TT_FAILLOG_EN adds first_fail/fail_seen (first
// mismatching vector of a run).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin a run (accepted only in IDLE)
//   dut_a/dut_b  registered gate inputs
//   dut_out      gate output under test
//   busy         run in progress (APPLY/CHECK)
//   done         one-cycle end-of-run pulse
//   pass         last run had no mismatches
//   err_count    mismatches in last run (0..4)
//   first_fail   {a,b} of first mismatch (GATE_TT_FAILLOG_EN only)
//   fail_seen    a mismatch was captured (GATE_TT_FAILLOG_EN only)
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int unsigned          SETTLE_CYCLES = 2,
    parameter logic [VEC_COUNT-1:0] EXPECT_TT     = TT_AND
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef GATE_TT_FAILLOG_EN
    ,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_seen
`endif
);

    generate
        if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
            $error("gate_tt_checker: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             timer_load, timer_dec, timer_zero;
    logic             mismatch_c;

    // X/Z on the gate output must count as a mismatch, hence the case equality.
    assign mismatch_c = !(dut_out === tt_expect(EXPECT_TT, vec_q));

    gate_tt_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timer_load),
        .dec_i    (timer_dec),
        .value_i  (SETTLE_LOAD),
        .zero_c_o (timer_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY:   if (timer_zero) state_d = CHECK;
            CHECK:   state_d = (vec_q == VEC_W'(VEC_COUNT - 1)) ? DONE : APPLY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; everything visible at the ports is registered.
    always_comb begin
        vec_d      = vec_q;
        err_d      = err_q;
        pass_d     = pass_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d      = '0;
                    err_d      = '0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            APPLY: begin
                timer_dec = 1'b1;
            end
            CHECK: begin
                if (mismatch_c) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (vec_q != VEC_W'(VEC_COUNT - 1)) begin
                    vec_d      = vec_q + VEC_W'(1);
                    timer_load = 1'b1;
                end else begin
                    // Include this final comparison so pass is valid alongside done.
                    pass_d = (err_d == '0);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == APPLY) || (state_d == CHECK);
        done_d = (state_d == DONE);
        a_d    = busy_d ? vec_d[1] : 1'b0;
        b_d    = busy_d ? vec_d[0] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q  <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            err_q  <= err_d;
            pass_q <= pass_d;
            busy_q <= busy_d;
            done_q <= done_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    assign dut_a     = a_q;
    assign dut_b     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef GATE_TT_FAILLOG_EN
    logic [VEC_W-1:0] ff_q, ff_d;
    logic             fs_q, fs_d;

    // Capture only the first mismatch of a run; cleared when a run is accepted.
    always_comb begin
        ff_d = ff_q;
        fs_d = fs_q;
        if ((state_q == IDLE) && start) begin
            ff_d = '0;
            fs_d = 1'b0;
        end else if ((state_q == CHECK) && mismatch_c && !fs_q) begin
            ff_d = vec_q;
            fs_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_q <= '0;
            fs_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
            fs_q <= fs_d;
        end
    end

    assign first_fail = ff_q;
    assign fail_seen  = fs_q;
`else
    // No fail log: only the aggregate err_count/pass are kept.
`endif

endmodule
